// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants (640x480@60 defaults), pixel type and axis-size helpers.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 11;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 31;
    localparam int DEF_COLOR_W  = 4;

    typedef logic [3*DEF_COLOR_W-1:0] pixel_t;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int axis_width(input int active, input int fp, input int sync, input int bp);
        return $clog2(axis_total(active, fp, sync, bp));
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with active/sync region decode.
// Segment order is active, front porch, sync, back porch.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   advance,
    output logic [axis_width(ACTIVE, FP, SYNC, BP)-1:0] cnt,
    output logic                                   wrap,
    output logic                                   in_active,
    output logic                                   in_sync
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam int W     = axis_width(ACTIVE, FP, SYNC, BP);
    localparam int W1    = W + 1;

    localparam logic [W-1:0]  LAST     = W'(TOTAL - 1);
    // One extra bit so region ends equal to TOTAL stay representable.
    localparam logic [W1-1:0] ACT_END  = W1'(ACTIVE);
    localparam logic [W1-1:0] SYNC_BEG = W1'(ACTIVE + FP);
    localparam logic [W1-1:0] SYNC_END = W1'(ACTIVE + FP + SYNC);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (advance) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt       = cnt_q;
    assign wrap      = advance && (cnt_q == LAST);
    assign in_active = ({1'b0, cnt_q} < ACT_END);
    assign in_sync   = ({1'b0, cnt_q} >= SYNC_BEG) && ({1'b0, cnt_q} < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: pixel-rate enable, sync/colour outputs, line fetch requests.
// All pin outputs are registered and update one clk after each pixel-enable cycle.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int PIX_DIV  = 2,
    parameter int COLOR_W  = DEF_COLOR_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [3*COLOR_W-1:0]        pix_data,
    input  logic                        pix_valid,
    output logic                        pix_ready,
    output logic                        line_req,
    output logic [$clog2(V_ACTIVE)-1:0] line_req_num,
    output logic                        frame_start,
    output logic                        underflow,
    input  logic                        underflow_clr,
    output logic [COLOR_W-1:0]          vga_r,
    output logic [COLOR_W-1:0]          vga_g,
    output logic [COLOR_W-1:0]          vga_b,
    output logic                        vga_hs,
    output logic                        vga_vs,
    output logic                        vga_pixel_clock
);

    localparam int HW      = axis_width(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int VW      = axis_width(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int VW1     = VW + 1;
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int LW      = $clog2(V_ACTIVE);
    localparam int DW      = $clog2(PIX_DIV);
    localparam int CW      = 3 * COLOR_W;

    localparam logic [DW-1:0]  DIV_LAST  = DW'(PIX_DIV - 1);
    localparam logic [DW-1:0]  DIV_HALF  = DW'(PIX_DIV / 2);
    localparam logic [HW-1:0]  H_REQ     = HW'(H_ACTIVE);
    localparam logic [VW-1:0]  V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW1-1:0] V_ACT_END = VW1'(V_ACTIVE);
    localparam logic           HS_ACT    = 1'(HS_POL);
    localparam logic           VS_ACT    = 1'(VS_POL);

    logic           run, cnt_clr, pix_en, active;
    logic [DW-1:0]  div_q, div_d;
    logic           pclk_q, pclk_d;
    logic [HW-1:0]  h_cnt;
    logic [VW-1:0]  v_cnt, v_next;
    logic           h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;
    logic           line_req_q, line_req_d;
    logic [LW-1:0]  num_q, num_d;
    logic           frame_start_q, frame_start_d;
    logic           first_q, first_d;
    logic           underflow_q, underflow_d;
    logic [CW-1:0]  rgb_q, rgb_d;
    logic           hs_q, hs_d, vs_q, vs_d;

    assign run     = enable & ~reset;
    assign cnt_clr = ~run;
    assign pix_en  = run && (div_q == DIV_LAST);
    assign active  = h_act & v_act;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h_axis (
        .clk(clk), .reset(cnt_clr), .advance(pix_en),
        .cnt(h_cnt), .wrap(h_wrap), .in_active(h_act), .in_sync(h_sync)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v_axis (
        .clk(clk), .reset(cnt_clr), .advance(h_wrap),
        .cnt(v_cnt), .wrap(v_wrap), .in_active(v_act), .in_sync(v_sync)
    );

    always_comb begin
        div_d = '0;
        if (run && !pix_en) begin
            div_d = div_q + 1'b1;
        end
        pclk_d = (div_d >= DIV_HALF);

        // Request the upcoming line one full line ahead, so line 0 goes out during the last line.
        v_next     = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        line_req_d = pix_en && (h_cnt == H_REQ) && ({1'b0, v_next} < V_ACT_END);
        num_d      = line_req_d ? v_next[LW-1:0] : num_q;

        frame_start_d = pix_en && (first_q || v_wrap);
        first_d       = !run ? 1'b1 : (pix_en ? 1'b0 : first_q);
        underflow_d   = (pix_en && active && !pix_valid) || (underflow_q && !underflow_clr);

        rgb_d = rgb_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        if (!run) begin
            rgb_d = '0;
            hs_d  = ~HS_ACT;
            vs_d  = ~VS_ACT;
        end else if (pix_en) begin
            rgb_d = (active && pix_valid) ? pix_data : '0;
            hs_d  = h_sync ? HS_ACT : ~HS_ACT;
            vs_d  = v_sync ? VS_ACT : ~VS_ACT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q         <= '0;
            pclk_q        <= 1'b0;
            line_req_q    <= 1'b0;
            num_q         <= '0;
            frame_start_q <= 1'b0;
            first_q       <= 1'b1;
            underflow_q   <= 1'b0;
            rgb_q         <= '0;
            hs_q          <= ~HS_ACT;
            vs_q          <= ~VS_ACT;
        end else begin
            div_q         <= div_d;
            pclk_q        <= pclk_d;
            line_req_q    <= line_req_d;
            num_q         <= num_d;
            frame_start_q <= frame_start_d;
            first_q       <= first_d;
            underflow_q   <= underflow_d;
            rgb_q         <= rgb_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
        end
    end

    assign pix_ready       = pix_en & active;
    assign line_req        = line_req_q;
    assign line_req_num    = num_q;
    assign frame_start     = frame_start_q;
    assign underflow       = underflow_q;
    assign vga_r           = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign vga_g           = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign vga_b           = rgb_q[COLOR_W-1:0];
    assign vga_hs          = hs_q;
    assign vga_vs          = vs_q;
    assign vga_pixel_clock = pclk_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: small 14x7 raster (both sync polarities) plus the default 800x524 raster.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    logic   clk = 1'b0;
    logic   reset, enable, pix_valid, underflow_clr;
    pixel_t dat;
    int     tests = 0;
    int     fails = 0;

    always #5 clk = ~clk;

    logic       sm_ready, sm_req, sm_fs, sm_uf, sm_hs, sm_vs, sm_pclk;
    logic [1:0] sm_num;
    logic [3:0] sm_r, sm_g, sm_b;
    logic       inv_ready, inv_req, inv_fs, inv_uf, inv_hs, inv_vs, inv_pclk;
    logic [1:0] inv_num;
    logic [3:0] inv_r, inv_g, inv_b;
    logic       def_ready, def_req, def_fs, def_uf, def_hs, def_vs, def_pclk;
    logic [8:0] def_num;
    logic [3:0] def_r, def_g, def_b;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .PIX_DIV(2), .COLOR_W(4)
    ) u_sm (
        .clk(clk), .reset(reset), .enable(enable), .pix_data(dat), .pix_valid(pix_valid),
        .pix_ready(sm_ready), .line_req(sm_req), .line_req_num(sm_num), .frame_start(sm_fs),
        .underflow(sm_uf), .underflow_clr(underflow_clr), .vga_r(sm_r), .vga_g(sm_g), .vga_b(sm_b),
        .vga_hs(sm_hs), .vga_vs(sm_vs), .vga_pixel_clock(sm_pclk)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .PIX_DIV(2), .COLOR_W(4)
    ) u_inv (
        .clk(clk), .reset(reset), .enable(enable), .pix_data(dat), .pix_valid(pix_valid),
        .pix_ready(inv_ready), .line_req(inv_req), .line_req_num(inv_num), .frame_start(inv_fs),
        .underflow(inv_uf), .underflow_clr(underflow_clr), .vga_r(inv_r), .vga_g(inv_g), .vga_b(inv_b),
        .vga_hs(inv_hs), .vga_vs(inv_vs), .vga_pixel_clock(inv_pclk)
    );

    vga_timing_gen u_def (
        .clk(clk), .reset(reset), .enable(enable), .pix_data(dat), .pix_valid(pix_valid),
        .pix_ready(def_ready), .line_req(def_req), .line_req_num(def_num), .frame_start(def_fs),
        .underflow(def_uf), .underflow_clr(underflow_clr), .vga_r(def_r), .vga_g(def_g), .vga_b(def_b),
        .vga_hs(def_hs), .vga_vs(def_vs), .vga_pixel_clock(def_pclk)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_num, ready_cnt;
        logic uf_exp;
        int low0, low1, first_low, vs_low, req_n, req_num, fs_cnt, pclk_hi;

        reset = 1'b1; enable = 1'b1; pix_valid = 1'b1; underflow_clr = 1'b0; dat = 12'h5a3;
        repeat (3) tick();

        check("rst_rgb",  32'({sm_r, sm_g, sm_b}), 32'd0);
        check("rst_hs",   32'(sm_hs), 32'd1);
        check("rst_vs",   32'(sm_vs), 32'd1);
        check("rst_pclk", 32'(sm_pclk), 32'd0);
        check("rst_req",  32'(sm_req), 32'd0);
        check("rst_num",  32'(sm_num), 32'd0);
        check("rst_fs",   32'(sm_fs), 32'd0);
        check("rst_uf",   32'(sm_uf), 32'd0);
        check("rst_ready", 32'(sm_ready), 32'd0);
        check("rst_inv_hs", 32'(inv_hs), 32'd0);
        check("rst_inv_vs", 32'(inv_vs), 32'd0);
        check("rst_inv_misc", 32'({inv_ready, inv_req, inv_num, inv_fs, inv_uf, inv_pclk, inv_r, inv_g, inv_b}), 32'd0);
        check("rst_def_hs", 32'(def_hs), 32'd1);

        reset = 1'b0;
        tick();
        check("p0_fs",   32'(sm_fs), 32'd0);
        check("p0_pclk", 32'(sm_pclk), 32'd1);

        // Two full small frames; pixel k has its pix_en cycle between edges 2k and 2k+1.
        exp_num = 0; uf_exp = 1'b0; ready_cnt = 0;
        for (int k = 0; k < 196; k++) begin
            int   h, v;
            logic act, vld, clr, req_e, fs_e;
            h   = k % 14;
            v   = (k / 14) % 7;
            act = (h < 8) && (v < 4);
            vld = !(k == 3 || k == 5);
            clr = (k == 5 || k == 20);
            pix_valid = vld; underflow_clr = clr;
            check("ready", 32'(sm_ready), 32'(act));
            if (k >= 98 && sm_ready) ready_cnt++;
            tick();
            pix_valid = 1'b1; underflow_clr = 1'b0;
            if (act && !vld) uf_exp = 1'b1;
            else if (clr) uf_exp = 1'b0;
            req_e = (h == 8) && (((v + 1) % 7) < 4);
            if (req_e) exp_num = (v + 1) % 7;
            fs_e = (k == 0) || (h == 13 && v == 6);
            check("rgb",    32'({sm_r, sm_g, sm_b}), 32'((act && vld) ? dat : 12'h000));
            check("hs",     32'(sm_hs), 32'((h >= 10 && h < 12) ? 1'b0 : 1'b1));
            check("vs",     32'(sm_vs), 32'((v == 5) ? 1'b0 : 1'b1));
            check("inv_hs", 32'(inv_hs), 32'((h >= 10 && h < 12) ? 1'b1 : 1'b0));
            check("inv_vs", 32'(inv_vs), 32'((v == 5) ? 1'b1 : 1'b0));
            check("req",    32'(sm_req), 32'(req_e));
            check("num",    32'(sm_num), 32'(exp_num));
            check("fs",     32'(sm_fs), 32'(fs_e));
            check("uf",     32'(sm_uf), 32'(uf_exp));
            check("pclk_lo", 32'(sm_pclk), 32'd0);
            if (act && vld) dat = dat + 12'h137;
            tick();
            check("pulse_end", 32'({sm_fs, sm_req}), 32'd0);
            check("pclk_hi", 32'(sm_pclk), 32'd1);
        end
        check("ready_per_frame", 32'(ready_cnt), 32'd32);

        // Drop enable mid-frame, then restart at (0,0).
        tick();
        check("en_pre_rgb", 32'({sm_r, sm_g, sm_b}), 32'(dat));
        dat = dat + 12'h137;
        enable = 1'b0;
        tick();
        check("en0_rgb",   32'({sm_r, sm_g, sm_b}), 32'd0);
        check("en0_hs",    32'({sm_hs, sm_vs, inv_hs, inv_vs}), 32'b1100);
        check("en0_ready", 32'(sm_ready), 32'd0);
        check("en0_pclk",  32'(sm_pclk), 32'd0);
        repeat (3) tick();
        check("en0_hold", 32'({sm_ready, sm_req, sm_fs, sm_pclk}), 32'd0);
        enable = 1'b1;
        tick();
        check("en1_ready", 32'(sm_ready), 32'd1);
        check("en1_fs0",   32'(sm_fs), 32'd0);
        tick();
        check("en1_fs",  32'(sm_fs), 32'd1);
        check("en1_rgb", 32'({sm_r, sm_g, sm_b}), 32'(dat));

        // Default raster: underflow then reset mid-line at h_cnt=300.
        reset = 1'b1; tick(); reset = 1'b0; tick();
        for (int n = 1; n <= 600; n++) begin
            tick();
            pix_valid = (n != 200);
        end
        check("mid_uf",  32'(def_uf), 32'd1);
        check("mid_rgb", 32'({def_r, def_g, def_b}), 32'(dat));
        reset = 1'b1;
        tick();
        check("mrst_rgb",   32'({def_r, def_g, def_b}), 32'd0);
        check("mrst_sync",  32'({def_hs, def_vs}), 32'b11);
        check("mrst_pclk",  32'(def_pclk), 32'd0);
        check("mrst_pulse", 32'({def_req, def_fs, def_ready}), 32'd0);
        check("mrst_num",   32'(def_num), 32'd0);
        check("mrst_uf",    32'(def_uf), 32'd0);
        check("mrst_sm_num", 32'(sm_num), 32'd0);
        reset = 1'b0;
        tick();
        check("mrel_fs0",  32'(def_fs), 32'd0);
        check("mrel_pclk", 32'(def_pclk), 32'd1);

        low0 = 0; low1 = 0; first_low = -1; vs_low = 0; req_n = -1; req_num = -1; fs_cnt = 0; pclk_hi = 0;
        for (int n = 1; n <= 3200; n++) begin
            tick();
            if (n == 1) begin
                check("mrel_fs",  32'(def_fs), 32'd1);
                check("mrel_rgb", 32'({def_r, def_g, def_b}), 32'(dat));
            end else if (def_fs) begin
                fs_cnt++;
            end
            if (!def_hs) begin
                if (first_low < 0) first_low = n;
                if (n < 1600) low0++;
                else low1++;
            end
            if (!def_vs) vs_low++;
            if (def_req && req_n < 0) begin
                req_n = n;
                req_num = int'(def_num);
            end
            if (def_pclk) pclk_hi++;
        end
        check("def_hs_first", 32'(first_low), 32'd1313);
        check("def_hs_line0", 32'(low0), 32'd192);
        check("def_hs_line1", 32'(low1), 32'd192);
        check("def_vs_low",   32'(vs_low), 32'd0);
        check("def_req_pos",  32'(req_n), 32'd1281);
        check("def_req_num",  32'(req_num), 32'd1);
        check("def_fs_extra", 32'(fs_cnt), 32'd0);
        check("def_pclk_hi",  32'(pclk_hi), 32'd1600);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
